// File: rtl/satd_had_acc.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : satd_had_acc                                                 |
// | Description : Row-streamed block cost unit; SATD via separable 2-D         |
// |               Hadamard or plain SAD, one result per ROWS-row block.        |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module satd_had_acc #(
    parameter int BIT_DEPTH = 8,
    parameter int COLS      = 8,
    parameter int ROWS      = 4,
    localparam int LC       = $clog2(COLS),
    localparam int LR       = $clog2(ROWS),
    localparam int SW       = BIT_DEPTH + 2 * (LC + LR)
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [COLS*BIT_DEPTH-1:0] ORG,
    input  logic [COLS*BIT_DEPTH-1:0] CUR,
    input  logic                      mode,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [SW-1:0]             out_sum,
    output logic                      out_mode
);

    localparam int CW = BIT_DEPTH + 1 + LC + LR;
    localparam logic [LR-1:0] C_LAST_ROW = LR'(ROWS - 1);

    localparam logic [1:0] ST_COLLECT = 2'd0;
    localparam logic [1:0] ST_CALC    = 2'd1;
    localparam logic [1:0] ST_HOLD    = 2'd2;

    logic [1:0]           r_state;
    logic [1:0]           w_state_nxt;
    logic [LR-1:0]        r_row_cnt;
    logic                 r_mode;
    logic                 w_accept;
    logic                 w_row_mode;
    logic signed [CW-1:0] r_buf [ROWS][COLS];
    logic signed [CW-1:0] w_row [LC+1][COLS];
    logic signed [CW-1:0] w_col [LR+1][ROWS][COLS];
    logic signed [CW-1:0] w_coef;
    logic [CW-1:0]        w_mag;
    logic [SW-1:0]        w_sum;

    assign w_accept   = in_valid & in_ready;
    // Row 0 latches the block mode, so its own transform must follow the live input.
    assign w_row_mode = (r_row_cnt == '0) ? mode : r_mode;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= ST_COLLECT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_COLLECT: if (w_accept && (r_row_cnt == C_LAST_ROW)) w_state_nxt = ST_CALC;
            ST_CALC:    w_state_nxt = ST_HOLD;
            ST_HOLD:    if (out_ready) w_state_nxt = ST_COLLECT;
            default:    w_state_nxt = ST_COLLECT;
        endcase
    end

    always_comb begin
        in_ready  = !RST && (r_state == ST_COLLECT);
        out_valid = !RST && (r_state == ST_HOLD);
    end

    // Horizontal Hadamard on the incoming difference row (natural/Sylvester order).
    always_comb begin
        for (int k = 0; k < COLS; k++) begin
            w_row[0][k] = CW'($signed({1'b0, ORG[k*BIT_DEPTH +: BIT_DEPTH]})
                            - $signed({1'b0, CUR[k*BIT_DEPTH +: BIT_DEPTH]}));
        end
        for (int s = 0; s < LC; s++) begin
            for (int k = 0; k < COLS; k++) begin
                if (((k >> s) & 1) == 0)
                    w_row[s+1][k] = w_row[s][k] + w_row[s][k ^ (1 << s)];
                else
                    w_row[s+1][k] = w_row[s][k ^ (1 << s)] - w_row[s][k];
            end
        end
    end

    // Vertical Hadamard over the buffered block, then sum of magnitudes.
    always_comb begin
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                w_col[0][r][c] = r_buf[r][c];
        for (int s = 0; s < LR; s++) begin
            for (int r = 0; r < ROWS; r++) begin
                for (int c = 0; c < COLS; c++) begin
                    if (((r >> s) & 1) == 0)
                        w_col[s+1][r][c] = w_col[s][r][c] + w_col[s][r ^ (1 << s)][c];
                    else
                        w_col[s+1][r][c] = w_col[s][r ^ (1 << s)][c] - w_col[s][r][c];
                end
            end
        end
        w_sum  = '0;
        w_coef = '0;
        w_mag  = '0;
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                w_coef = r_mode ? w_col[LR][r][c] : w_col[0][r][c];
                w_mag  = (w_coef < 0) ? CW'(-w_coef) : CW'(w_coef);
                w_sum  = w_sum + SW'(w_mag);
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (w_accept) begin
            for (int k = 0; k < COLS; k++)
                r_buf[r_row_cnt][k] <= w_row_mode ? w_row[LC][k] : w_row[0][k];
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_row_cnt <= '0;
            r_mode    <= 1'b0;
            out_sum   <= '0;
            out_mode  <= 1'b0;
        end else begin
            if (w_accept) begin
                if (r_row_cnt == '0) r_mode <= mode;
                r_row_cnt <= (r_row_cnt == C_LAST_ROW) ? '0 : r_row_cnt + 1'b1;
            end
            if (r_state == ST_CALC) begin
                out_sum  <= w_sum;
                out_mode <= r_mode;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_satd_had_acc.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_satd_had_acc                                              |
// | Description : Directed bench for satd_had_acc against a matrix-form model. |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module tb_satd_had_acc;

    localparam int BD = 8;
    localparam int NC = 8;
    localparam int NR = 4;
    localparam int SW = 18;

    logic             CLK = 1'b0;
    logic             RST = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [NC*BD-1:0] ORG = '0;
    logic [NC*BD-1:0] CUR = '0;
    logic             mode = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [SW-1:0]    out_sum;
    logic             out_mode;

    int errors = 0;
    int checks = 0;

    typedef struct {
        int sum;
        bit m;
    } exp_t;
    exp_t exp_q[$];

    int org_a[NR][NC];
    int cur_a[NR][NC];

    satd_had_acc #(.BIT_DEPTH(BD), .COLS(NC), .ROWS(NR)) dut (
        .CLK(CLK), .RST(RST), .in_valid(in_valid), .in_ready(in_ready),
        .ORG(ORG), .CUR(CUR), .mode(mode), .out_valid(out_valid),
        .out_ready(out_ready), .out_sum(out_sum), .out_mode(out_mode)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Hadamard matrix entry in Sylvester order: (-1)^popcount(i&j).
    function automatic int had(int i, int j);
        return ($countones(i & j) % 2) ? -1 : 1;
    endfunction

    function automatic int model_sum(bit m);
        int s = 0;
        for (int u = 0; u < NR; u++) begin
            for (int v = 0; v < NC; v++) begin
                int c = 0;
                if (m) begin
                    for (int r = 0; r < NR; r++)
                        for (int k = 0; k < NC; k++)
                            c += had(u, r) * had(v, k) * (org_a[r][k] - cur_a[r][k]);
                end else begin
                    c = org_a[u][v] - cur_a[u][v];
                end
                s += (c < 0) ? -c : c;
            end
        end
        return s;
    endfunction

    task automatic fill(input int o, input int c);
        for (int r = 0; r < NR; r++)
            for (int k = 0; k < NC; k++) begin
                org_a[r][k] = o;
                cur_a[r][k] = c;
            end
    endtask

    task automatic drive_row(input int r);
        for (int k = 0; k < NC; k++) begin
            ORG[k*BD +: BD] = BD'(org_a[r][k]);
            CUR[k*BD +: BD] = BD'(cur_a[r][k]);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // Rows after row 0 carry the opposite mode, which the block must ignore.
    task automatic send_block(input bit m, input int nrows);
        for (int r = 0; r < nrows; r++) begin
            in_valid = 1'b1;
            mode     = (r == 0) ? m : ~m;
            drive_row(r);
            @(negedge CLK);
            check("in_ready_collect", in_ready, 1);
            step();
        end
        in_valid = 1'b0;
        if (nrows == NR) exp_q.push_back('{sum: model_sum(m), m: m});
    endtask

    task automatic run_block(input bit m, input int exp, input bit pin);
        if (pin) check("model_pin", model_sum(m), exp);
        send_block(m, NR);
        check("lat_calc_valid", out_valid, 0);
        step();
        check("lat_hold_valid", out_valid, 1);
        check("block_sum", out_sum, exp);
        check("block_mode", out_mode, m);
        step();
        check("release_valid", out_valid, 0);
        check("release_ready", in_ready, 1);
    endtask

    // Every consumed result is compared against the model queue.
    always @(negedge CLK) begin
        if (!RST && out_valid) begin
            check("hold_in_ready", in_ready, 0);
            if (out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_result", 1, 0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("model_sum", out_sum, e.sum);
                    check("model_mode", out_mode, e.m);
                end
            end
        end
    end

    initial begin
        repeat (3) step();
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_sum", out_sum, 0);
        check("rst_out_mode", out_mode, 0);
        RST = 1'b0;
        #1;
        check("post_rst_in_ready", in_ready, 1);
        step();

        fill(77, 77);       run_block(1'b1, 0, 1'b1);
        fill(10, 0);        run_block(1'b1, 320, 1'b1);
        run_block(1'b0, 320, 1'b1);
        fill(0, 0);  org_a[0][0] = 1;
        run_block(1'b1, 32, 1'b1);
        run_block(1'b0, 1, 1'b1);
        fill(0, 255);       run_block(1'b1, 8160, 1'b1);
        run_block(1'b0, 8160, 1'b1);

        for (int r = 0; r < NR; r++)
            for (int k = 0; k < NC; k++) begin
                org_a[r][k] = ((r * 8 + k) * 37) % 256;
                cur_a[r][k] = (k * 31 + r * 13 + 5) % 256;
            end
        run_block(1'b1, model_sum(1'b1), 1'b0);
        run_block(1'b0, model_sum(1'b0), 1'b0);

        // Backpressure: result must hold while extra rows are refused.
        out_ready = 1'b0;
        fill(10, 0);
        send_block(1'b1, NR);
        step();
        fill(3, 200);
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            drive_row(0);
            check("bp_valid", out_valid, 1);
            check("bp_sum", out_sum, 320);
            check("bp_in_ready", in_ready, 0);
            step();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        check("bp_release_valid", out_valid, 0);
        check("bp_release_ready", in_ready, 1);

        // Reset after a partial block; the stale rows must not leak.
        fill(200, 0);
        send_block(1'b1, 2);
        RST      = 1'b1;
        in_valid = 1'b1;
        drive_row(0);
        step();
        check("mid_rst_in_ready", in_ready, 0);
        RST      = 1'b0;
        in_valid = 1'b0;
        fill(10, 0);
        run_block(1'b1, 320, 1'b1);

        step();
        check("queue_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
`default_nettype wire
